// File: rtl/fmlarb_pkg.sv
// Shared constants for the FML arbiter data-ack queue: default latencies,
// default outstanding depth, and the legal parameter limits.
package fmlarb_pkg;

    localparam int READ_LAT_DEF  = 5;
    localparam int WRITE_LAT_DEF = 2;
    localparam int MAX_OUT_DEF   = 1;
    localparam int LAT_MAX       = 15;
    localparam int MAX_OUT_LIMIT = 15;

    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/fmlarb_dly.sv
// One-bit pulse delay line with two injection points: a pulse injected with
// long_i=1 emerges LAT+1 cycles later, with long_i=0 it emerges after LAT cycles.
module fmlarb_dly
    import fmlarb_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_i,
    input  logic long_i,
    output logic pulse_o
);

    if (!in_range(LAT, 1, LAT_MAX)) begin : g_bad_lat
        $error("fmlarb_dly: LAT out of range");
    end

    logic [LAT:0] sr_q;
    logic [LAT:0] sr_d;

    // Stage 0 is only reachable through the long tap; stage 1 merges the
    // shifted long-tap pulse with a fresh short-tap pulse.
    always_comb begin
        sr_d    = {sr_q[LAT-1:0], 1'b0};
        sr_d[0] = pulse_i & long_i;
        sr_d[1] = sr_q[0] | (pulse_i & ~long_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign pulse_o = sr_q[LAT];

endmodule

// File: rtl/fmlarb_dackq.sv
// Turns early acks from the memory controller into final data acks with
// fixed read/write latency, tracks outstanding transfers and masks the strobe.
module fmlarb_dackq
    import fmlarb_pkg::*;
#(
    parameter int READ_LAT  = READ_LAT_DEF,
    parameter int WRITE_LAT = WRITE_LAT_DEF,
    parameter int MAX_OUT   = MAX_OUT_DEF
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst_n,
    input  logic                             tim_cas,
    input  logic                             stb,
    input  logic                             eack,
    input  logic                             we,
    output logic                             stbm,
    output logic                             ack,
    output logic                             ack_we,
    output logic [$clog2(MAX_OUT+1)-1:0]     outstanding,
    output logic                             err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_N = CW'(MAX_OUT);
    localparam logic [CW:0]   MAX_W = (CW + 1)'(MAX_OUT);

    if (!in_range(READ_LAT, 1, LAT_MAX)) begin : g_bad_read_lat
        $error("fmlarb_dackq: READ_LAT out of range");
    end
    if (!in_range(WRITE_LAT, 1, LAT_MAX)) begin : g_bad_write_lat
        $error("fmlarb_dackq: WRITE_LAT out of range");
    end
    if (!in_range(MAX_OUT, 1, MAX_OUT_LIMIT)) begin : g_bad_max_out
        $error("fmlarb_dackq: MAX_OUT out of range");
    end

    logic rd_ack;
    logic wr_ack;
    logic collision;

    fmlarb_dly #(.LAT(READ_LAT)) u_rd_dly (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .pulse_i (eack & ~we),
        .long_i  (tim_cas),
        .pulse_o (rd_ack)
    );

    fmlarb_dly #(.LAT(WRITE_LAT)) u_wr_dly (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .pulse_i (eack & we),
        .long_i  (1'b0),
        .pulse_o (wr_ack)
    );

    // A read/write collision is folded into one ack reported as a write.
    assign collision = rd_ack & wr_ack;
    assign ack       = rd_ack | wr_ack;
    assign ack_we    = wr_ack;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          err_q;
    logic          err_d;
    logic [CW:0]   cnt_sum;
    logic [CW:0]   cnt_dec;
    logic [CW:0]   cnt_ext;
    logic          full;
    logic          empty;

    assign full  = (cnt_q == MAX_N);
    assign empty = (cnt_q == '0);

    // Widened arithmetic so the count can floor at zero and saturate at MAX_OUT.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + {{CW{1'b0}}, eack};
        cnt_dec = collision ? (CW + 1)'(2) : {{CW{1'b0}}, ack};
        if (cnt_sum <= cnt_dec) begin
            cnt_ext = '0;
        end else begin
            cnt_ext = cnt_sum - cnt_dec;
        end
        if (cnt_ext > MAX_W) begin
            cnt_d = MAX_N;
        end else begin
            cnt_d = cnt_ext[CW-1:0];
        end
        err_d = err_q | (eack & full & ~ack) | (ack & empty) | collision;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign stbm        = stb & (cnt_q < MAX_N);
    assign outstanding = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fmlarb_dackq.sv
// Bench for fmlarb_dackq: default instance (MAX_OUT=1) and a MAX_OUT=4 instance
// share stimulus; directed scenarios plus randomized traffic against a model.
module tb_fmlarb_dackq;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       tim_cas = 1'b0;
    logic       stb = 1'b0;
    logic       eack = 1'b0;
    logic       we = 1'b0;

    logic       stbm_a, ack_a, ack_we_a, err_a;
    logic [0:0] out_a;
    logic       stbm_b, ack_b, ack_we_b, err_b;
    logic [2:0] out_b;

    int checks = 0;
    int failures = 0;
    int c = 0;

    always #5 sys_clk = ~sys_clk;

    fmlarb_dackq dut_a (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .tim_cas     (tim_cas),
        .stb         (stb),
        .eack        (eack),
        .we          (we),
        .stbm        (stbm_a),
        .ack         (ack_a),
        .ack_we      (ack_we_a),
        .outstanding (out_a),
        .err         (err_a)
    );

    fmlarb_dackq #(.READ_LAT(5), .WRITE_LAT(2), .MAX_OUT(4)) dut_b (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .tim_cas     (tim_cas),
        .stb         (stb),
        .eack        (eack),
        .we          (we),
        .stbm        (stbm_b),
        .ack         (ack_b),
        .ack_we      (ack_we_b),
        .outstanding (out_b),
        .err         (err_b)
    );

    // One bench cycle: inputs applied just after the edge, outputs settled after.
    task automatic drive(input logic s, input logic e, input logic w, input logic cs);
        @(posedge sys_clk);
        #1;
        stb = s;
        eack = e;
        we = w;
        tim_cas = cs;
        #1;
        c++;
    endtask

    task automatic do_reset;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        stb = 1'b0;
        eack = 1'b0;
        we = 1'b0;
        tim_cas = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        c = -1;
    endtask

    task automatic test_reset;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        stb = 1'b1;
        #1;
        checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL reset_ack_a got=%b want=0", ack_a); end
        checks++; if (out_a !== 1'b0) begin failures++; $display("FAIL reset_out_a got=%0d want=0", out_a); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err_a got=%b want=0", err_a); end
        checks++; if (stbm_a !== 1'b1) begin failures++; $display("FAIL reset_stbm_a got=%b want=1", stbm_a); end
        checks++; if (out_b !== 3'd0) begin failures++; $display("FAIL reset_out_b got=%0d want=0", out_b); end
        checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL reset_err_b got=%b want=0", err_b); end
        do_reset;
        $display("test_reset done");
    endtask

    task automatic test_write_latency;
        logic exp_ack;
        logic busy;
        do_reset;
        for (int i = 0; i <= 16; i++) begin
            drive(1'b1, i == 10, 1'b1, 1'b0);
            exp_ack = (c == 12);
            busy = (c == 11) || (c == 12);
            checks++; if (ack_a !== exp_ack) begin failures++; $display("FAIL wr_ack c=%0d got=%b want=%b", c, ack_a, exp_ack); end
            checks++; if (stbm_a !== !busy) begin failures++; $display("FAIL wr_stbm c=%0d got=%b want=%b", c, stbm_a, !busy); end
            checks++; if (out_a !== busy) begin failures++; $display("FAIL wr_out c=%0d got=%0d want=%0d", c, out_a, busy); end
            checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL wr_err c=%0d got=%b want=0", c, err_a); end
            if (exp_ack) begin
                checks++; if (ack_we_a !== 1'b1) begin failures++; $display("FAIL wr_ack_we c=%0d got=%b want=1", c, ack_we_a); end
            end
        end
        $display("test_write_latency done");
    endtask

    task automatic test_read_latency;
        logic exp_ack;
        logic busy;
        do_reset;
        for (int i = 0; i <= 30; i++) begin
            drive(1'b1, (i == 10) || (i == 20), 1'b0, i == 20);
            exp_ack = (c == 15) || (c == 26);
            busy = (c >= 11 && c <= 15) || (c >= 21 && c <= 26);
            checks++; if (ack_a !== exp_ack) begin failures++; $display("FAIL rd_ack c=%0d got=%b want=%b", c, ack_a, exp_ack); end
            checks++; if (out_a !== busy) begin failures++; $display("FAIL rd_out c=%0d got=%0d want=%0d", c, out_a, busy); end
            checks++; if (stbm_a !== !busy) begin failures++; $display("FAIL rd_stbm c=%0d got=%b want=%b", c, stbm_a, !busy); end
            if (exp_ack) begin
                checks++; if (ack_we_a !== 1'b0) begin failures++; $display("FAIL rd_ack_we c=%0d got=%b want=0", c, ack_we_a); end
            end
        end
        $display("test_read_latency done");
    endtask

    task automatic test_max_out;
        int n_eack;
        int n_ack;
        int exp_cnt;
        logic exp_ack;
        do_reset;
        for (int i = 0; i <= 22; i++) begin
            drive(1'b1, i >= 10 && i <= 13, 1'b0, 1'b0);
            n_eack = (c <= 10) ? 0 : ((c >= 14) ? 4 : c - 10);
            n_ack = (c <= 15) ? 0 : ((c >= 19) ? 4 : c - 15);
            exp_cnt = n_eack - n_ack;
            exp_ack = (c >= 15 && c <= 18);
            checks++; if (int'(out_b) !== exp_cnt) begin failures++; $display("FAIL max_out_cnt c=%0d got=%0d want=%0d", c, out_b, exp_cnt); end
            checks++; if (ack_b !== exp_ack) begin failures++; $display("FAIL max_out_ack c=%0d got=%b want=%b", c, ack_b, exp_ack); end
            checks++; if (stbm_b !== (exp_cnt < 4)) begin failures++; $display("FAIL max_out_stbm c=%0d got=%b want=%b", c, stbm_b, exp_cnt < 4); end
            checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL max_out_err c=%0d got=%b want=0", c, err_b); end
        end
        $display("test_max_out done");
    endtask

    task automatic test_collision;
        int exp_b;
        logic exp_ack;
        do_reset;
        for (int i = 0; i <= 20; i++) begin
            drive(1'b1, (i == 10) || (i == 13), i == 13, 1'b0);
            exp_ack = (c == 15);
            exp_b = (c >= 11 && c <= 13) ? 1 : ((c == 14 || c == 15) ? 2 : 0);
            checks++; if (ack_b !== exp_ack) begin failures++; $display("FAIL coll_ack_b c=%0d got=%b want=%b", c, ack_b, exp_ack); end
            checks++; if (int'(out_b) !== exp_b) begin failures++; $display("FAIL coll_out_b c=%0d got=%0d want=%0d", c, out_b, exp_b); end
            checks++; if (err_b !== (c >= 16)) begin failures++; $display("FAIL coll_err_b c=%0d got=%b want=%b", c, err_b, c >= 16); end
            checks++; if (err_a !== (c >= 14)) begin failures++; $display("FAIL coll_err_a c=%0d got=%b want=%b", c, err_a, c >= 14); end
            checks++; if (out_a !== (c >= 11 && c <= 15)) begin failures++; $display("FAIL coll_out_a c=%0d got=%0d want=%0d", c, out_a, c >= 11 && c <= 15); end
            if (exp_ack) begin
                checks++; if (ack_we_b !== 1'b1) begin failures++; $display("FAIL coll_ack_we c=%0d got=%b want=1", c, ack_we_b); end
            end
        end
        $display("test_collision done");
    endtask

    task automatic test_reset_in_flight;
        logic s;
        do_reset;
        for (int i = 0; i <= 11; i++) begin
            drive(1'b1, i == 10, 1'b0, 1'b0);
        end
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        c = 12;
        checks++; if (out_a !== 1'b0) begin failures++; $display("FAIL rstf_out_a got=%0d want=0", out_a); end
        checks++; if (out_b !== 3'd0) begin failures++; $display("FAIL rstf_out_b got=%0d want=0", out_b); end
        checks++; if (stbm_a !== stb) begin failures++; $display("FAIL rstf_stbm got=%b want=%b", stbm_a, stb); end
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        c = 13;
        for (int i = 14; i <= 22; i++) begin
            s = 1'($urandom_range(0, 1));
            drive(s, 1'b0, 1'b0, 1'b0);
            checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL rstf_ack c=%0d got=%b want=0", c, ack_a); end
            checks++; if (out_a !== 1'b0) begin failures++; $display("FAIL rstf_cnt c=%0d got=%0d want=0", c, out_a); end
            checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL rstf_err c=%0d got=%b want=0", c, err_a); end
            checks++; if (stbm_a !== s) begin failures++; $display("FAIL rstf_stbm c=%0d got=%b want=%b", c, stbm_a, s); end
        end
        $display("test_reset_in_flight done");
    endtask

    // Model: acks scheduled by absolute cycle, counters/err per the stated rules.
    task automatic test_random;
        bit rd_due[int];
        bit wr_due[int];
        int m_cnt[2];
        bit m_err[2];
        int maxo[2];
        int n;
        bit rd, wr, xa, compliant;
        logic s, e, w, cs;
        maxo[0] = 1;
        maxo[1] = 4;
        for (int seg = 0; seg < 7; seg++) begin
            do_reset;
            rd_due.delete();
            wr_due.delete();
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_err[0] = 1'b0; m_err[1] = 1'b0;
            compliant = (seg == 0);
            for (int i = 0; i < (compliant ? 800 : 150); i++) begin
                s = 1'($urandom_range(0, 1));
                if (compliant)
                    e = s && (m_cnt[0] < 1) && ($urandom_range(0, 2) != 0);
                else
                    e = ($urandom_range(0, 99) < 40);
                w = 1'($urandom_range(0, 1));
                cs = 1'($urandom_range(0, 1));
                drive(s, e, w, cs);
                rd = rd_due.exists(c);
                wr = wr_due.exists(c);
                xa = rd || wr;
                checks++; if (ack_a !== xa) begin failures++; $display("FAIL rnd_ack_a seg=%0d c=%0d got=%b want=%b", seg, c, ack_a, xa); end
                checks++; if (ack_b !== xa) begin failures++; $display("FAIL rnd_ack_b seg=%0d c=%0d got=%b want=%b", seg, c, ack_b, xa); end
                checks++; if (int'(out_a) !== m_cnt[0]) begin failures++; $display("FAIL rnd_out_a seg=%0d c=%0d got=%0d want=%0d", seg, c, out_a, m_cnt[0]); end
                checks++; if (int'(out_b) !== m_cnt[1]) begin failures++; $display("FAIL rnd_out_b seg=%0d c=%0d got=%0d want=%0d", seg, c, out_b, m_cnt[1]); end
                checks++; if (err_a !== m_err[0]) begin failures++; $display("FAIL rnd_err_a seg=%0d c=%0d got=%b want=%b", seg, c, err_a, m_err[0]); end
                checks++; if (err_b !== m_err[1]) begin failures++; $display("FAIL rnd_err_b seg=%0d c=%0d got=%b want=%b", seg, c, err_b, m_err[1]); end
                checks++; if (stbm_a !== (s && m_cnt[0] < maxo[0])) begin failures++; $display("FAIL rnd_stbm_a seg=%0d c=%0d got=%b", seg, c, stbm_a); end
                checks++; if (stbm_b !== (s && m_cnt[1] < maxo[1])) begin failures++; $display("FAIL rnd_stbm_b seg=%0d c=%0d got=%b", seg, c, stbm_b); end
                if (xa) begin
                    checks++; if (ack_we_a !== wr) begin failures++; $display("FAIL rnd_ack_we_a seg=%0d c=%0d got=%b want=%b", seg, c, ack_we_a, wr); end
                    checks++; if (ack_we_b !== wr) begin failures++; $display("FAIL rnd_ack_we_b seg=%0d c=%0d got=%b want=%b", seg, c, ack_we_b, wr); end
                end
                for (int k = 0; k < 2; k++) begin
                    if (e && m_cnt[k] == maxo[k] && !xa) m_err[k] = 1'b1;
                    if (xa && m_cnt[k] == 0) m_err[k] = 1'b1;
                    if (rd && wr) m_err[k] = 1'b1;
                    n = m_cnt[k] + (e ? 1 : 0) - ((rd && wr) ? 2 : (xa ? 1 : 0));
                    if (n < 0) n = 0;
                    if (n > maxo[k]) n = maxo[k];
                    m_cnt[k] = n;
                end
                if (rd) rd_due.delete(c);
                if (wr) wr_due.delete(c);
                if (e) begin
                    if (w) wr_due[c + 2] = 1'b1;
                    else   rd_due[c + 5 + (cs ? 1 : 0)] = 1'b1;
                end
            end
            $display("test_random segment %0d done", seg);
        end
    endtask

    initial begin
        test_reset;
        test_write_latency;
        test_read_latency;
        test_max_out;
        test_collision;
        test_reset_in_flight;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
